// File: rtl/clk_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the clock
// run/pause/single-step controller.
package clk_ctrl_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_SET_DIV = 2'd0;
    localparam logic [1:0] OP_RUN     = 2'd1;
    localparam logic [1:0] OP_PAUSE   = 2'd2;
    localparam logic [1:0] OP_STEP    = 2'd3;

    // Controller states, also exported on the state debug output
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP     = 2'd2,
        ST_STOPPING = 2'd3
    } state_e;

    // True while the divided clock is free-running or stepping
    // (i.e. PAUSE is meaningful and a new STEP is illegal)
    function automatic logic is_active(state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/clk_step_ctrl_if.sv
// Command port of the clock controller.
// Handshake: a command transfers on the I_CLK rising edge where cmd_valid
// and cmd_ready are both high; the master holds cmd_op/cmd_arg stable while
// cmd_valid is high, and cmd_ready may drop without a command being offered.
// cmd_err is a one-cycle pulse the cycle after an illegal command transfers.
interface clk_step_ctrl_if #(
    parameter int ARG_W = 16
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [ARG_W-1:0] cmd_arg;
    logic             cmd_err;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready,
        output cmd_err
    );

endinterface

// File: rtl/clk_phase_gen.sv
// Divided-clock phase generator: half-period counter, registered O_CLK,
// registered tick at each rise, and the ratio register. A new ratio is
// loaded either immediately (controller idle, counter parked at 0) or on
// the falling toggle, so no phase is ever shortened or stretched.
module clk_phase_gen #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_now,
    input  logic [DIV_W-1:0] load_val,
    input  logic             pend_vld,
    input  logic [DIV_W-1:0] pend_val,
    output logic             o_clk,
    output logic             tick,
    output logic             rise_evt,
    output logic             fall_evt,
    output logic [DIV_W-1:0] div_cur
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             o_clk_q, o_clk_d;
    logic             tick_q, tick_d;
    logic             hit;

    // Toggle detection: end of the current half-period at the ratio in force
    always_comb begin
        hit      = (cnt_q == (div_q - ONE));
        rise_evt = en && hit && !o_clk_q;
        fall_evt = en && hit && o_clk_q;
    end

    // Next counter, clock level, tick and ratio
    always_comb begin
        cnt_d   = cnt_q;
        o_clk_d = o_clk_q;
        div_d   = div_q;
        tick_d  = rise_evt;
        if (!en) begin
            cnt_d   = '0;
            o_clk_d = 1'b0;
        end else if (hit) begin
            cnt_d   = '0;
            o_clk_d = !o_clk_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end
        if (load_now) begin
            div_d = load_val;
        end else if (fall_evt && pend_vld) begin
            div_d = pend_val;
        end
    end

    // Phase state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            o_clk_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            o_clk_q <= o_clk_d;
            tick_q  <= tick_d;
        end
    end

    assign o_clk   = o_clk_q;
    assign tick    = tick_q;
    assign div_cur = div_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/pause/single-step controller for the board-to-CPU clock. Decodes
// commands, sequences IDLE/RUN/STEP/STOPPING, counts step ticks and holds
// a ratio change until the next falling toggle of O_CLK.
module clk_step_ctrl #(
    parameter int DIV_W       = 16,
    parameter int ARG_W       = 16,   // must be >= DIV_W
    parameter int DEFAULT_DIV = 2     // must be >= 1
) (
    input  logic              I_CLK,
    input  logic              rst_n,
    clk_step_ctrl_if.slave    cmd,
    output logic              O_CLK,
    output logic              tick,
    output logic [1:0]        state,
    output logic [DIV_W-1:0]  div_cur,
    output logic [ARG_W-1:0]  step_left
);

    import clk_ctrl_pkg::*;

    localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
    localparam logic [ARG_W-1:0] ONE_A = ARG_W'(1);

    state_e           state_q, state_d;
    logic [ARG_W-1:0] step_q, step_d;
    logic             pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             err_q, err_d;

    logic             cmd_fire;
    logic             cmd_ready_w;
    logic [DIV_W-1:0] arg_lo;
    logic [DIV_W-1:0] arg_div;
    logic             load_now;
    logic             run_en;
    logic             rise_evt;
    logic             fall_evt;

    // No command while a ratio waits for its falling toggle or while draining
    assign cmd_ready_w = !pend_vld_q && (state_q != ST_STOPPING);
    assign cmd_fire    = cmd.cmd_valid && cmd_ready_w;

    // A ratio of zero is meaningless; treat it as the fastest ratio
    assign arg_lo  = cmd.cmd_arg[DIV_W-1:0];
    assign arg_div = (arg_lo == '0) ? ONE_D : arg_lo;

    // The divider runs in every state except IDLE
    assign run_en = (state_q != ST_IDLE);

    // FSM next state, step counter, pending ratio and command decode
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        err_d      = 1'b0;
        load_now   = 1'b0;

        // Autonomous progress from divider events
        case (state_q)
            ST_STEP: begin
                if (rise_evt) begin
                    step_d = step_q - ONE_A;
                    if (step_q == ONE_A) begin
                        state_d = ST_STOPPING;
                    end
                end
            end
            ST_STOPPING: begin
                if (fall_evt) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // The phase generator consumes the pending ratio on this toggle
        if (fall_evt && pend_vld_q) begin
            pend_vld_d = 1'b0;
        end

        // Accepted command overrides the autonomous step where they overlap
        if (cmd_fire) begin
            case (cmd.cmd_op)
                OP_SET_DIV: begin
                    if (state_q == ST_IDLE) begin
                        load_now = 1'b1;
                    end else begin
                        pend_vld_d = 1'b1;
                        pend_val_d = arg_div;
                    end
                end
                OP_RUN: begin
                    if (state_q == ST_IDLE || state_q == ST_STEP) begin
                        state_d = ST_RUN;
                        step_d  = '0;
                    end
                end
                OP_PAUSE: begin
                    if (is_active(state_q)) begin
                        state_d = ST_STOPPING;
                    end
                end
                OP_STEP: begin
                    if (is_active(state_q)) begin
                        err_d = 1'b1;
                    end else if (state_q == ST_IDLE && cmd.cmd_arg != '0) begin
                        state_d = ST_STEP;
                        step_d  = cmd.cmd_arg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Controller registers
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            err_q      <= err_d;
        end
    end

    clk_phase_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_phase (
        .clk      (I_CLK),
        .rst_n    (rst_n),
        .en       (run_en),
        .load_now (load_now),
        .load_val (arg_div),
        .pend_vld (pend_vld_q),
        .pend_val (pend_val_q),
        .o_clk    (O_CLK),
        .tick     (tick),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt),
        .div_cur  (div_cur)
    );

    assign cmd.cmd_ready = cmd_ready_w;
    assign cmd.cmd_err   = err_q;
    assign state         = state_q;
    assign step_left     = step_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: expected tick edges are queued when commands are
// issued and popped by a tick monitor; a phase monitor checks every complete
// O_CLK half-period against the ratio in force when it began.
module tb_clk_step_ctrl;

    import clk_ctrl_pkg::*;

    logic        I_CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        O_CLK;
    logic        tick;
    logic [1:0]  state;
    logic [15:0] div_cur;
    logic [15:0] step_left;

    clk_step_ctrl_if #(.ARG_W(16)) cmd_if ();

    clk_step_ctrl #(
        .DIV_W       (16),
        .ARG_W       (16),
        .DEFAULT_DIV (2)
    ) dut (
        .I_CLK     (I_CLK),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .O_CLK     (O_CLK),
        .tick      (tick),
        .state     (state),
        .div_cur   (div_cur),
        .step_left (step_left)
    );

    // Clock and edge counter (cyc == number of rising edges seen)
    always #5 I_CLK = ~I_CLK;

    int cyc = 0;
    always @(posedge I_CLK) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    bit          phase_chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Tick monitor: each tick must match the next expected edge
    always @(negedge I_CLK) begin : tick_mon
        logic [31:0] e;
        if (rst_n && tick) begin
            if (exp_q.size() == 0) begin
                check_eq("tick_unexpected", {31'd0, tick}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("tick_cycle", cyc, e);
            end
        end
    end

    // Phase monitor: each complete half-period lasts div_cur cycles
    int          ph_start = 0;
    logic [31:0] ph_len   = 0;
    bit          ph_valid = 1'b0;
    logic        prev_o   = 1'b0;
    always @(negedge I_CLK) begin
        if (!rst_n || !phase_chk_en) begin
            ph_valid = 1'b0;
        end else begin
            if (O_CLK !== prev_o) begin
                if (ph_valid) check_eq("phase_len", cyc - ph_start, ph_len);
                ph_start = cyc;
                ph_len   = {16'd0, div_cur};
                ph_valid = 1'b1;
            end
            if (state == 2'd0) ph_valid = 1'b0;
        end
        prev_o = O_CLK;
    end

    // Wait (at negedges) until edge number target has passed
    task automatic wait_edge(input int target);
        while (cyc < target) @(negedge I_CLK);
    endtask

    // Issue one command from a negedge; returns the accepting edge number
    task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg, output int k);
        int g;
        g = 0;
        while (!cmd_if.cmd_ready && g < 50) begin
            @(negedge I_CLK);
            g++;
        end
        check_eq("cmd_ready_wait", {31'd0, cmd_if.cmd_ready}, 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        @(posedge I_CLK);
        #1;
        k = cyc;
        cmd_if.cmd_valid = 1'b0;
        @(negedge I_CLK);
    endtask

    task automatic push_tick(input int e);
        exp_q.push_back(e);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k, k2, p;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_arg   = 16'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge I_CLK);
        check_eq("rst_in_oclk", {31'd0, O_CLK}, 0);
        check_eq("rst_in_state", state, 0);
        check_eq("rst_in_div", div_cur, 2);
        rst_n = 1'b1;
        @(negedge I_CLK);
        check_eq("rst_oclk", {31'd0, O_CLK}, 0);
        check_eq("rst_tick", {31'd0, tick}, 0);
        check_eq("rst_err", {31'd0, cmd_if.cmd_err}, 0);
        check_eq("rst_state", state, 0);
        check_eq("rst_div", div_cur, 2);
        check_eq("rst_step", step_left, 0);
        check_eq("rst_ready", {31'd0, cmd_if.cmd_ready}, 1);
        phase_chk_en = 1'b1;

        // RUN at default ratio 2, then PAUSE during a high phase
        send_cmd(OP_RUN, 16'd0, k);
        push_tick(k + 2); push_tick(k + 6); push_tick(k + 10); push_tick(k + 14);
        check_eq("run_state", state, 1);
        wait_edge(k + 14);
        send_cmd(OP_PAUSE, 16'd0, p);
        check_eq("pause_stopping", state, 3);
        check_eq("pause_ready", {31'd0, cmd_if.cmd_ready}, 0);
        check_eq("pause_oclk_hi", {31'd0, O_CLK}, 1);
        wait_edge(k + 16);
        check_eq("pause_idle", state, 0);
        check_eq("pause_oclk_lo", {31'd0, O_CLK}, 0);
        wait_edge(k + 20);
        check_eq("sb_drain_run", exp_q.size(), 0);

        // STEP 3 from IDLE
        send_cmd(OP_STEP, 16'd3, k);
        push_tick(k + 2); push_tick(k + 6); push_tick(k + 10);
        check_eq("step_state", state, 2);
        check_eq("step_left_3", step_left, 3);
        wait_edge(k + 2);
        check_eq("step_left_2", step_left, 2);
        wait_edge(k + 6);
        check_eq("step_left_1", step_left, 1);
        wait_edge(k + 10);
        check_eq("step_left_0", step_left, 0);
        check_eq("step_stopping", state, 3);
        wait_edge(k + 11);
        check_eq("step_hi_last", {31'd0, O_CLK}, 1);
        wait_edge(k + 12);
        check_eq("step_idle", state, 0);
        check_eq("step_oclk_lo", {31'd0, O_CLK}, 0);
        wait_edge(k + 18);
        check_eq("sb_drain_step", exp_q.size(), 0);

        // Ratio 4, RUN, then SET_DIV 7 during a high phase
        send_cmd(OP_SET_DIV, 16'd4, k);
        check_eq("setdiv_idle", div_cur, 4);
        send_cmd(OP_RUN, 16'd0, k2);
        push_tick(k2 + 4);
        wait_edge(k2 + 5);
        send_cmd(OP_SET_DIV, 16'd7, k);
        push_tick(k2 + 15); push_tick(k2 + 29);
        check_eq("pend_ready", {31'd0, cmd_if.cmd_ready}, 0);
        check_eq("pend_div_old", div_cur, 4);
        check_eq("pend_oclk_hi", {31'd0, O_CLK}, 1);
        wait_edge(k2 + 7);
        check_eq("pend_ready_hold", {31'd0, cmd_if.cmd_ready}, 0);
        wait_edge(k2 + 8);
        check_eq("pend_div_new", div_cur, 7);
        check_eq("pend_ready_back", {31'd0, cmd_if.cmd_ready}, 1);
        check_eq("pend_oclk_lo", {31'd0, O_CLK}, 0);
        wait_edge(k2 + 30);
        send_cmd(OP_PAUSE, 16'd0, p);
        check_eq("pause7_stopping", state, 3);
        wait_edge(k2 + 35);
        check_eq("pause7_still", state, 3);
        check_eq("pause7_hi", {31'd0, O_CLK}, 1);
        wait_edge(k2 + 36);
        check_eq("pause7_idle", state, 0);
        wait_edge(k2 + 40);
        check_eq("sb_drain_div7", exp_q.size(), 0);

        // SET_DIV 0 clamps to 1; illegal STEP while running
        send_cmd(OP_SET_DIV, 16'd0, k);
        check_eq("clamp_div", div_cur, 1);
        check_eq("clamp_no_err", {31'd0, cmd_if.cmd_err}, 0);
        send_cmd(OP_RUN, 16'd0, k2);
        push_tick(k2 + 1); push_tick(k2 + 3); push_tick(k2 + 5);
        push_tick(k2 + 7); push_tick(k2 + 9); push_tick(k2 + 11);
        wait_edge(k2 + 7);
        send_cmd(OP_STEP, 16'd5, k);
        check_eq("err_pulse", {31'd0, cmd_if.cmd_err}, 1);
        check_eq("err_state_run", state, 1);
        check_eq("err_step_left", step_left, 0);
        wait_edge(k2 + 9);
        check_eq("err_pulse_end", {31'd0, cmd_if.cmd_err}, 0);
        wait_edge(k2 + 10);
        send_cmd(OP_PAUSE, 16'd0, p);
        check_eq("pause1_stopping", state, 3);
        wait_edge(k2 + 12);
        check_eq("pause1_idle", state, 0);
        check_eq("pause1_oclk", {31'd0, O_CLK}, 0);
        wait_edge(k2 + 16);
        check_eq("sb_drain_div1", exp_q.size(), 0);

        // Async reset in the middle of a STEP at ratio 3
        send_cmd(OP_SET_DIV, 16'd3, k);
        send_cmd(OP_STEP, 16'd4, k2);
        push_tick(k2 + 3); push_tick(k2 + 9);
        wait_edge(k2 + 10);
        check_eq("mid_step_left", step_left, 2);
        check_eq("mid_step_hi", {31'd0, O_CLK}, 1);
        phase_chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_oclk", {31'd0, O_CLK}, 0);
        check_eq("arst_tick", {31'd0, tick}, 0);
        check_eq("arst_state", state, 0);
        check_eq("arst_div", div_cur, 2);
        check_eq("arst_step", step_left, 0);
        check_eq("arst_err", {31'd0, cmd_if.cmd_err}, 0);
        @(negedge I_CLK);
        rst_n = 1'b1;
        @(negedge I_CLK);
        check_eq("post_rst_ready", {31'd0, cmd_if.cmd_ready}, 1);
        check_eq("post_rst_state", state, 0);
        check_eq("sb_drain_rst", exp_q.size(), 0);
        phase_chk_en = 1'b1;

        // Recovery: RUN again at the default ratio
        send_cmd(OP_RUN, 16'd0, k);
        push_tick(k + 2); push_tick(k + 6);
        wait_edge(k + 7);
        check_eq("sb_drain_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
